cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle fetch/execute sequencer for the 3-bit-opcode core. Owns the program counter, and steps each instruction through the FETCH, EXEC and WB phases, with optional data-memory wait states. Qualifies the control decoder's level outputs (RegWrite, MemWrite, MemtoReg, Branch) into single-cycle strobes. Provides the start/done handshake to the test harness.

## Interface
- PW, 10: program counter width; PC wraps modulo 2^PW.
- MEM_LAT, 1: data-memory read latency in cycles; legal range 1..7.
- CNT_W, 16: width of the performance counters (only with SEQ_PERF_CNT_EN).

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  run request; sampled only in IDLE or DONE.
- halt_pc  in  PW  address of the last instruction; the sequencer halts after its WB.
- dec_reg_write, dec_mem_write, dec_mem_to_reg, dec_branch  in  1 each  decoder outputs for the instruction held in IR.
- branch_taken  in  1  register-equality compare result from the datapath; valid in WB.
- branch_target  in  PW  branch destination; valid in WB.
- pc  out  PW  current instruction address to the instruction ROM.
- ir_load  out  1  IR capture strobe.
- mem_re  out  1  data-memory read strobe.
- mem_we  out  1  data-memory write strobe.
- reg_we  out  1  register-file write strobe.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- instr_count, cycle_count  out  CNT_W each  present only with SEQ_PERF_CNT_EN.

## Operation
- States: IDLE, FETCH, EXEC, MEMWAIT, WB, DONE.
- IDLE: all strobes are 0. When start=1: pc<=0, next state FETCH.
- FETCH: ir_load=1; next state EXEC.
- EXEC:
  - If dec_mem_to_reg: mem_re=1, the wait counter loads MEM_LAT-1, next state MEMWAIT.
  - Else if dec_mem_write: mem_we=1, next state WB.
  - Else: next state WB.
- MEMWAIT: stays until the wait counter reaches 0, decrementing once per cycle; then next state WB.
- WB:
  - reg_we = dec_reg_write & ~dec_mem_write.
  - PC update: pc <= (dec_branch & branch_taken) ? branch_target : pc+1.
  - Halt check: if the pre-update pc == halt_pc, next state DONE; otherwise next state FETCH.
- DONE: done=1 and pc is held. When start=1: pc<=0, next state FETCH, and done drops on the following cycle.
- start is ignored while busy=1.
- Strobes are decoded from the state register only, with no registered outputs, so each strobe is high for exactly one cycle per instruction.
- Arithmetic: pc+1 is computed in PW bits, so 2^PW-1 wraps to 0. A branch to halt_pc halts only after that instruction itself executes.

## Timing
- Reset (async assert): state=IDLE, pc=0, busy=0, done=0, all strobes 0, wait counter 0, perf counters 0. Release is synchronous to clk.
- Reset asserted mid-instruction aborts the instruction immediately; no partial write strobe may appear after rst_n falls.
- Instruction latency: 3 cycles for non-loads, 3+MEM_LAT cycles for loads.
- start sampled at edge N: FETCH occupies cycle N+1.
- Strobe cycles: ir_load in FETCH; mem_re/mem_we in EXEC; reg_we and the PC update in WB.
- done rises in the cycle after the final WB.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - instr_count increments on each WB.
  - cycle_count increments on every busy cycle.
  - Both clear when start is accepted and saturate at all-ones.
  - Both hold their values in DONE.
- SEQ_PERF_CNT_EN undefined: both ports and all counter logic are absent.

## Structure
- seq_pkg holds:
  - the state enum (seq_state_t);
  - opcode localparams matching the decoder (OP_ADD=000, OP_ROR=001, OP_NAND=010, OP_LD=011, OP_ST=100, OP_MOV=101, OP_BEQ=111);
  - MEM_LAT_MAX=7.
- One sub-module, seq_perf_ctr, holds one saturating counter; it is instantiated twice and only under SEQ_PERF_CNT_EN.

## Test plan
- Three ALU instructions, halt_pc=2, start pulsed at edge 0:
  - pc=0,1,2 in successive FETCHes;
  - reg_we high in cycles 3, 6 and 9;
  - done=1 from cycle 10, pc holds at 3.
- Load with MEM_LAT=2:
  - mem_re high for one cycle in EXEC;
  - two MEMWAIT cycles;
  - reg_we in WB;
  - instruction spans 5 cycles.
- Store: mem_we is high for exactly one cycle in EXEC and reg_we=0 in WB.
- Branch:
  - dec_branch=1, branch_taken=1, branch_target=0x2A: next FETCH pc=0x2A;
  - branch_taken=0: next FETCH pc=pc+1.
- PW=4, pc=15, halt_pc=3: next pc=0.
- start pulsed while busy: no effect.
- start in DONE: restart at pc=0 and done drops.
- rst_n dropped during EXEC of a store: mem_we=0, pc=0 and state=IDLE with no clock edge needed.
- With SEQ_PERF_CNT_EN, after the three-ALU program: instr_count=3, cycle_count=9.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the cpu_sequencer slice: phase enum, decoder
// opcode map and the data-memory latency ceiling.
`timescale 1ns/1ps
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEMWAIT,
    ST_WB,
    ST_DONE
  } seq_state_t;

  // Opcode encodings shared with the control decoder.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ROR  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LD   = 3'b011;
  localparam logic [2:0] OP_ST   = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b111;

  localparam int MEM_LAT_MAX = 7;
  localparam int WAIT_W      = 3;

  // Wait-counter preload for a given read latency, clamped into 1..MEM_LAT_MAX.
  function automatic logic [WAIT_W-1:0] wait_init(input int lat);
    int l;
    l = (lat < 1) ? 1 : ((lat > MEM_LAT_MAX) ? MEM_LAT_MAX : lat);
    return WAIT_W'(l - 1);
  endfunction

endpackage

// File: rtl/seq_perf_ctr.sv
// Single saturating performance counter; clear takes priority over increment.
`timescale 1ns/1ps
module seq_perf_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                         count_d = '0;
    else if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/MEMWAIT/WB sequencer owning the PC and strobe timing.
// Define SEQ_PERF_CNT_EN to add the instr_count/cycle_count performance counters.
`timescale 1ns/1ps
module cpu_sequencer
  import seq_pkg::*;
#(
  parameter int PW      = 10,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [PW-1:0] halt_pc,
  input  logic          dec_reg_write,
  input  logic          dec_mem_write,
  input  logic          dec_mem_to_reg,
  input  logic          dec_branch,
  input  logic          branch_taken,
  input  logic [PW-1:0] branch_target,
  output logic [PW-1:0] pc,
  output logic          ir_load,
  output logic          mem_re,
  output logic          mem_we,
  output logic          reg_we,
  output logic          busy,
  output logic          done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = wait_init(MEM_LAT);

  seq_state_t        state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    ir_load = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    reg_we  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_load = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_mem_to_reg) begin
          mem_re  = 1'b1;
          wait_d  = WAIT_INIT;
          state_d = ST_MEMWAIT;
        end else begin
          mem_we  = dec_mem_write;
          state_d = ST_WB;
        end
      end
      ST_MEMWAIT: begin
        if (wait_q == '0) state_d = ST_WB;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      ST_WB: begin
        reg_we  = dec_reg_write & ~dec_mem_write;
        pc_d    = (dec_branch & branch_taken) ? branch_target : pc_q + PW'(1);
        // Halt compares the address of the instruction just retired, not its successor.
        state_d = (pc_q == halt_pc) ? ST_DONE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
    end
  end

  assign pc   = pc_q;
  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done = (state_q == ST_DONE);

`ifdef SEQ_PERF_CNT_EN
  logic start_acc;
  assign start_acc = start & ~busy;

  seq_perf_ctr #(.W(CNT_W)) u_instr_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .inc   (state_q == ST_WB),
    .count (instr_count)
  );

  seq_perf_ctr #(.W(CNT_W)) u_cycle_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .inc   (busy),
    .count (cycle_count)
  );
`endif

endmodule
